// File: rtl/dmg_lcd_pkg.sv
// dmg_lcd_pkg: shared types, constants and helpers for the DMG LCD capture block.
package dmg_lcd_pkg;

  localparam int DMG_H_PIXELS = 160;
  localparam int DMG_V_LINES  = 144;

  typedef logic [1:0] pixel_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    HSYNC      = 2'd2
  } dmg_state_e;

  typedef struct packed {
    dmg_state_e state;
    logic       datal;
    logic       altsig;
  } dmg_dbg_t;

  // Bit positions of the panel pins in the synchronizer bank.
  localparam int PIN_D0     = 0;
  localparam int PIN_D1     = 1;
  localparam int PIN_HS     = 2;
  localparam int PIN_VS     = 3;
  localparam int PIN_CLK    = 4;
  localparam int PIN_DATAL  = 5;
  localparam int PIN_ALTSIG = 6;
  localparam int PIN_N      = 7;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmg_sync_edge.sv
// dmg_sync_edge: 2-flop synchronizer for one asynchronous pin plus an edge register
// producing the synchronized level and single-cycle rise/fall strobes.
module dmg_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/dmg_lcd_capture.sv
// dmg_lcd_capture: DMG LCD bus receiver producing addressed 2-bit framebuffer writes and
// frame/line markers. Define DMG_LCD_CAP_STATS_EN to build the frame_cnt/err_cnt counters.
module dmg_lcd_capture
  import dmg_lcd_pkg::*;
#(
  parameter int H_PIXELS = DMG_H_PIXELS,
  parameter int V_LINES  = DMG_V_LINES,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk_32m,
  input  logic        rst,
  input  logic        lcd_d0,
  input  logic        lcd_d1,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_clk,
  input  logic        lcd_datal,
  input  logic        lcd_altsig,
  output logic        pix_we,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output pixel_t      pix_data,
  output logic        frame_start,
  output logic        line_done,
  output logic        lcd_off,
  output logic        line_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output dmg_dbg_t    dbg
);

  localparam int             WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [7:0]     H_LIM  = 8'(H_PIXELS);
  localparam logic [7:0]     V_LIM  = 8'(V_LINES);

  logic [PIN_N-1:0] pin_raw, pin_lvl, pin_rise, pin_fall;

  assign pin_raw = {lcd_altsig, lcd_datal, lcd_clk, lcd_vsync, lcd_hsync, lcd_d1, lcd_d0};

  for (genvar i = 0; i < PIN_N; i++) begin : g_pin
    dmg_sync_edge u_sync (
      .clk  (clk_32m),
      .rst  (rst),
      .din  (pin_raw[i]),
      .level(pin_lvl[i]),
      .rise (pin_rise[i]),
      .fall (pin_fall[i])
    );
  end

  logic unused_pins;
  assign unused_pins = &{1'b0, pin_rise, pin_fall, pin_lvl};

  dmg_state_e      state;
  logic [7:0]      x, y, x_next;
  logic [WD_W-1:0] wd_cnt;
  logic            activity, wd_hit, px_strobe, new_frame;

  assign activity  = pin_rise[PIN_CLK] | pin_fall[PIN_CLK] | pin_rise[PIN_HS] | pin_fall[PIN_HS];
  assign wd_hit    = (wd_cnt == WD_MAX) && !activity;
  assign new_frame = pin_fall[PIN_HS] && pin_lvl[PIN_VS] && (state != ACTIVE);
  // A pixel clock fall coinciding with hsync rise still belongs to the closing line.
  assign px_strobe = pin_fall[PIN_CLK] && (!pin_lvl[PIN_HS] || pin_rise[PIN_HS]);
  assign x_next    = px_strobe ? sat_inc8(x) : x;

  always_ff @(posedge clk_32m or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (activity) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // pix_we is a valid-only strobe with no backpressure: pix_x/pix_y/pix_data are
  // meaningful only in the cycle pix_we is high and hold otherwise.
  always_ff @(posedge clk_32m or posedge rst) begin
    if (rst) begin
      state       <= WAIT_FRAME;
      x           <= '0;
      y           <= '0;
      pix_we      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      line_done   <= 1'b0;
      line_err    <= 1'b0;
      lcd_off     <= 1'b1;
    end else begin
      pix_we      <= 1'b0;
      frame_start <= 1'b0;
      line_done   <= 1'b0;
      line_err    <= 1'b0;
      if (wd_hit) begin
        lcd_off <= 1'b1;
        state   <= WAIT_FRAME;
      end else if (new_frame) begin
        x           <= '0;
        y           <= '0;
        frame_start <= 1'b1;
        lcd_off     <= 1'b0;
        state       <= ACTIVE;
      end else begin
        case (state)
          ACTIVE: begin
            if (px_strobe) begin
              if (x < H_LIM && y < V_LIM) begin
                pix_we   <= 1'b1;
                pix_x    <= x;
                pix_y    <= y;
                pix_data <= {pin_lvl[PIN_D1], pin_lvl[PIN_D0]};
              end
              x <= x_next;
            end
            if (pin_rise[PIN_HS]) begin
              state <= HSYNC;
              if (y < V_LIM) begin
                line_done <= 1'b1;
                line_err  <= (x_next != H_LIM);
              end
            end
          end
          HSYNC: begin
            if (pin_fall[PIN_HS]) begin
              y     <= sat_inc8(y);
              x     <= '0;
              state <= ACTIVE;
            end
          end
          default: state <= WAIT_FRAME;
        endcase
      end
    end
  end

`ifdef DMG_LCD_CAP_STATS_EN
  always_ff @(posedge clk_32m or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      if (line_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

  assign dbg.state  = state;
  assign dbg.datal  = pin_lvl[PIN_DATAL];
  assign dbg.altsig = pin_lvl[PIN_ALTSIG];

endmodule
